// File: rtl/div_seq_ctrl.sv
// Multi-cycle unsigned restoring divider sequencer for the MIPS DIV path.
// One shift-subtract step per clock; quotient goes to LO and remainder to HI.
module div_seq_ctrl #(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH:0]     r_q, r_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH:0]     r_sh;
  logic [WIDTH+1:0]   diff;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    d_d     = d_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    // Extra sign bit on the trial subtraction; R < D always, so the shifted R fits in WIDTH+1 bits.
    r_sh    = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    diff    = {r_q, q_q[WIDTH-1]} - {2'b00, d_q};

    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          q_d   = {q_q[WIDTH-2:0], ~diff[WIDTH+1]};
          r_d   = diff[WIDTH+1] ? r_sh : diff[WIDTH:0];
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            state_d = DONE;
            quo_d   = q_d;
            rem_d   = r_d[WIDTH-1:0];
            dbz_d   = 1'b0;
          end
        end
      end
      IDLE, DONE: begin
        state_d = IDLE;
        if (start && !flush) begin
          if (divisor == '0) begin
            state_d = DONE;
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
          end else begin
            state_d = RUN;
            q_d     = dividend;
            r_d     = '0;
            d_d     = divisor;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      d_q     <= d_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl: table of divides, then back-to-back, flush and
// mid-run reset sequences. Results are checked against an expected queue.
module tb_div_seq_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         flush;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  div_seq_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
  } vec_t;

  vec_t         vecs[8];
  logic [2*W:0] exp_q[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] last_q = '0;
  logic [W-1:0] last_r = '0;
  logic         last_z = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one start in the current cycle (cycle 0) and returns just after the edge ending it.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] eq, input logic [W-1:0] er,
                       input logic ez, input bit push);
    start    = 1'b1;
    dividend = x;
    divisor  = y;
    if (push) exp_q.push_back({eq, er, ez});
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Watches cycles c0.. at the falling edge; expects done exactly in cycle lat.
  task automatic wait_done(input int c0, input int lat, input bit run);
    bit           seen = 1'b0;
    logic [2*W:0] e;
    for (int c = c0; c <= lat + 3 && !seen; c++) begin
      @(negedge clk);
      check("busy", int'(busy), int'(run && c < lat));
      if (done) begin
        seen = 1'b1;
        check("latency", c, lat);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("quotient", int'(quotient), int'(e[2*W:W+1]));
          check("remainder", int'(remainder), int'(e[W:1]));
          check("div_by_zero", int'(div_by_zero), int'(e[0]));
          last_q = e[2*W:W+1];
          last_r = e[W:1];
          last_z = e[0];
        end
      end else begin
        check("hold_quotient", int'(quotient), int'(last_q));
        check("hold_remainder", int'(remainder), int'(last_r));
      end
    end
    if (!seen) check("done_timeout", 0, 1);
  endtask

  initial begin
    vecs[0] = '{4'd7,  4'd2,  4'd3,  4'd1,  1'b0};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0,  1'b0};
    vecs[2] = '{4'd3,  4'd5,  4'd0,  4'd3,  1'b0};
    vecs[3] = '{4'd9,  4'd0,  4'd15, 4'd9,  1'b1};
    vecs[4] = '{4'd0,  4'd7,  4'd0,  4'd0,  1'b0};
    vecs[5] = '{4'd15, 4'd15, 4'd1,  4'd0,  1'b0};
    vecs[6] = '{4'd8,  4'd3,  4'd2,  4'd2,  1'b0};
    vecs[7] = '{4'd0,  4'd0,  4'd15, 4'd0,  1'b1};

    rst_n = 1'b0; start = 1'b0; flush = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_quotient", int'(quotient), 0);
    check("rst_remainder", int'(remainder), 0);
    check("rst_dbz", int'(div_by_zero), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].x, vecs[i].y, vecs[i].eq, vecs[i].er, vecs[i].ez, 1'b1);
      wait_done(1, vecs[i].ez ? 1 : W + 1, !vecs[i].ez);
      @(negedge clk);
      check("done_one_cycle", int'(done), 0);
      @(posedge clk);
      #1;
    end

    // Random operands against a behavioural model.
    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] x, y;
      x = W'($urandom_range(0, (1 << W) - 1));
      y = W'($urandom_range(0, (1 << W) - 1));
      if (y == '0) issue(x, y, '1, x, 1'b1, 1'b1);
      else         issue(x, y, x / y, x % y, 1'b0, 1'b1);
      wait_done(1, (y == '0) ? 1 : W + 1, y != '0);
      @(posedge clk);
      #1;
    end

    // Back-to-back: start held in the DONE cycle.
    issue(4'd14, 4'd3, 4'd4, 4'd2, 1'b0, 1'b1);
    wait_done(1, W + 1, 1'b1);
    issue(4'd13, 4'd4, 4'd3, 4'd1, 1'b0, 1'b1);
    wait_done(1, W + 1, 1'b1);
    @(posedge clk);
    #1;

    // Flush in cycle 2 of 7/2, restart with 6/3 in cycle 3, stray start during its RUN.
    issue(4'd7, 4'd2, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_busy", int'(busy), 0);
    check("flush_done", int'(done), 0);
    check("flush_hold_q", int'(quotient), 3);
    check("flush_hold_r", int'(remainder), 1);
    issue(4'd6, 4'd3, 4'd2, 4'd0, 1'b0, 1'b1);
    start = 1'b1; dividend = 4'd15; divisor = 4'd1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2, W + 1, 1'b1);
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      check("ignored_start_done", int'(done), 0);
      check("ignored_start_busy", int'(busy), 0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset in cycle 3 of 11/2.
    issue(4'd11, 4'd2, '0, '0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", int'(busy), 0);
    check("async_done", int'(done), 0);
    check("async_quotient", int'(quotient), 0);
    check("async_remainder", int'(remainder), 0);
    check("async_dbz", int'(div_by_zero), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 0; c < W + 3; c++) begin
      @(negedge clk);
      check("post_rst_done", int'(done), 0);
      check("post_rst_busy", int'(busy), 0);
    end
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_seq_ctrl.md
Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the unsigned integer divider used by the MIPS DIV path.
- Accepts a start request with dividend/divisor and runs a restoring shift-subtract loop for WIDTH cycles.
- Returns quotient (LO) and remainder (HI) with a one-cycle done pulse.
- Provides busy for pipeline stall, flush for abort, and divide-by-zero detection.

Parameters:
- WIDTH, 4, operand/result width in bits; legal 2..32.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a divide; sampled only when state is not RUN.
- flush  input  1  abort the in-flight divide (pipeline flush).
- dividend  input  WIDTH  unsigned dividend x; sampled with start.
- divisor  input  WIDTH  unsigned divisor y; sampled with start.
- busy  output  1  high while the state is RUN.
- done  output  1  one-cycle pulse; results valid.
- quotient  output  WIDTH  registered quotient (LO).
- remainder  output  WIDTH  registered remainder (HI).
- div_by_zero  output  1  registered flag for the last completed op.

Behaviour:
- States: IDLE, RUN, DONE. Encoding is free; there are no illegal-state outputs, and unused encodings go to IDLE.
- Reset (async, rst_n=0):
  - State = IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal counter and working registers are cleared.
- Cycle numbering: cycle 0 is the cycle in which start=1 is sampled in IDLE or DONE.
- Accept, divisor != 0:
  - On the edge ending cycle 0, latch the dividend into working register Q, clear partial remainder R (WIDTH+1 bits), latch the divisor into D.
  - Counter = 0; state goes to RUN.
- RUN, cycles 1..WIDTH, one step per edge:
  - {R,Q} shifted left by 1.
  - T = R_shifted - {1'b0,D}.
  - If T is non-negative: R=T and Q[0]=1. Otherwise R is kept and Q[0]=0.
  - Counter increments. On the edge where the counter equals WIDTH-1, go to DONE and load quotient=Q_new, remainder=R_new[WIDTH-1:0], div_by_zero=0.
- DONE, cycle WIDTH+1:
  - done=1, busy=0.
  - Next state is RUN if start=1 (back-to-back accept, same rules as IDLE), else IDLE.
- Latency: done is high exactly in cycle WIDTH+1. Throughput is one op per WIDTH+1 cycles.
- Divide by zero (divisor==0 at accept):
  - Skip RUN and go directly to DONE; done is high in cycle 1.
  - quotient = all ones, remainder = dividend, div_by_zero = 1.
- Result outputs change only on entry to DONE. They hold their value through IDLE and through a following RUN until the next DONE.
- start while in RUN: ignored, with no effect on operands or timing.
- flush:
  - In RUN: the next state is IDLE, no done pulse, and result outputs keep their previous values.
  - In IDLE or DONE: it suppresses a simultaneous start, and the next state is IDLE.
  - flush has priority over start and over completion.
- Reset asserted mid-RUN: immediate return to IDLE with all outputs at their reset values. After deassertion the block waits for a fresh start.
- busy is a registered state decode (state==RUN); done is a state decode (state==DONE). Both are glitch-free from registers.

Test Plan:
- WIDTH=4, reset, then start with dividend=7, divisor=2 -> busy high in cycles 1-4, done high in cycle 5 only, quotient=3, remainder=1, div_by_zero=0.
- dividend=15, divisor=1 -> quotient=15, remainder=0. Then dividend=3, divisor=5 -> quotient=0, remainder=3. Each has done in cycle 5.
- dividend=9, divisor=0 -> done in cycle 1, quotient=4'b1111, remainder=9, div_by_zero=1, busy never high.
- 14/3 with start held high in the DONE cycle, carrying 13/4 -> first done gives q=4, r=2. Second op starts with no idle gap, and its done comes 5 cycles later with q=3, r=1 and div_by_zero=0.
- Start 7/2 and pulse flush in cycle 2, with start=1 again in cycle 3 for 6/3 -> no done for 7/2. Outputs keep prior values until the 6/3 done gives q=2, r=0. A start pulse during RUN of 6/3 (cycle 4 carrying 15/1) is ignored.
- Assert rst_n=0 asynchronously in cycle 3 of 11/2 -> outputs are zero immediately without a clock edge. After release, state is IDLE and no done appears until a new start.
